mat_result_serializer: RTL and testbench
========================================

Name: mat_result_serializer

Overview:
- Downstream stage of the matrix adders (tbt_adder for N=2, fbf_adder for N=4).
- Consumes the flat N*N x 32-bit IEEE-754 result word over the result_ready/result_ack handshake.
- Buffers the matrix and streams it out one element per transfer, row-major, over a valid/ready interface, e.g. to a UART/display or a later matrix stage.
- Frees the adder as soon as the capture is acknowledged.

Parameters:
- N, 4, matrix dimension (2 pairs with tbt_adder, 4 with fbf_adder); legal values 2..8.
- W, 32, element width in bits (single precision).

Ports:
- clk  in  1  system clock; single clock domain, rising edge.
- reset  in  1  asynchronous, active-low reset.
- result_ready  in  1  adder has a valid result on result.
- result  in  W*N*N  adder output; element k = result[W*k +: W], k = row*N + col.
- result_ack  out  1  acknowledge to adder (4-phase).
- out_ready  in  1  downstream accepts current element.
- out_valid  out  1  out_data/out_row/out_col/out_last valid.
- out_data  out  W  current element.
- out_row  out  clog2(N)  row index of out_data.
- out_col  out  clog2(N)  column index of out_data.
- out_last  out  1  high with the final element, k = N*N-1.
- busy  out  1  high whenever not in IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, idx=0, ack_pend=0, buffer=0.
  - All outputs 0: result_ack, out_valid, out_data, out_row, out_col, out_last, busy.
- Outputs are registered or decoded only from state/idx/ack_pend/buffer; there is no combinational path from any input to any output.
- States: IDLE, SEND, DRAIN.
- IDLE: on a clk edge with result_ready=1:
  - Latch result into buffer, set ack_pend=1, idx=0, go to SEND.
  - out_valid rises the cycle after result_ready is sampled high.
- ack_pend (independent of state):
  - result_ack = ack_pend.
  - Clears on the first edge where ack_pend=1 and result_ready=0.
  - result_ack therefore stays high until the adder drops result_ready, plus one cycle.
- SEND:
  - out_valid=1; out_data = buffer[W*idx +: W]; out_row = idx / N; out_col = idx % N; out_last = (idx == N*N-1).
  - A transfer happens on an edge with out_valid & out_ready.
  - Not last: idx increments.
  - Last and ack_pend=0: go to IDLE, idx=0.
  - Last and ack_pend=1: go to DRAIN.
  - out_ready=0: all out_* hold stable; no element is skipped or repeated.
- DRAIN: out_valid=0; when ack_pend clears go to IDLE. Every result is consumed exactly once (no double capture while result_ready is still high from the same result).
- result_ready high while in SEND/DRAIN is ignored until IDLE. In IDLE it is captured only if ack_pend=0, which always holds in IDLE.
- result changing while ack_pend=0 and not IDLE: ignored, since the buffer is written only in IDLE.
- Reset asserted mid-stream: immediate return to the reset values; the partial frame is discarded, and result_ack drops asynchronously.
- Throughput: N*N cycles per frame with out_ready tied high, plus 1 capture cycle. With the adder dropping result_ready 1 cycle after ack, back-to-back frames cost N*N+1 cycles.
- No arithmetic on data; elements pass through bit-exact (NaN/denormal untouched).

Decomposition:
- Shared package mat_pkg: W_FLOAT=32, state encoding (IDLE/SEND/DRAIN), an element-slicing function elem(bus,k).
- The same package is reused by tbt_adder/fbf_adder benches.
- No sub-module needed; single module with one FSM, one index counter and one ack flag.

Test Plan:
- 2x2 (N=2), out_ready=1, result = {C1000000, 40CAE148, C0947AE1, 41D5EB85} (MSB..LSB), result_ready held until ack:
  - Response: result_ack 1 cycle later.
  - out_data sequence 41D5EB85, C0947AE1, 40CAE148, C1000000.
  - (row,col) sequence (0,0), (0,1), (1,0), (1,1); out_last only on the 4th.
- 4x4 (N=4), out_ready toggled 1,0,0,1 pattern, result[31:0]=416D47AE and result[511:480]=41C6B852:
  - Response: 16 transfers, first 416D47AE, last 41C6B852 with out_last=1.
  - out_* stable on every out_ready=0 cycle.
- Adder holds result_ready high for 20 cycles after ack (slow release), N=2, stream finishes first:
  - Response: FSM enters DRAIN, result_ack stays 1 until result_ready=0, then 1 more cycle.
  - Only one frame emitted.
- Back-to-back frames, adder raises result_ready again the cycle after ack drops with new data 3F800000 x4:
  - Response: second frame captured only in IDLE; 4+4 elements emitted in order; no element lost or duplicated.
- reset pulled low during idx=2 of a 4x4 stream:
  - Response: out_valid, result_ack and busy fall immediately.
  - After release a fresh result streams from idx=0.
- out_ready=0 for 50 cycles at idx=0:
  - Response: out_valid=1, out_data constant, idx does not advance.
  - result_ack still completes its handshake independently.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared definitions for the matrix adder result path: element width,
// serializer state encoding and an element-slicing helper for flat result buses.
package mat_pkg;

   localparam int W_FLOAT = 32;
   localparam int N_MAX   = 8;
   localparam int BUS_MAX = W_FLOAT * N_MAX * N_MAX;
   localparam int BUS_AW  = $clog2(BUS_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Element k of a flat row-major bus (k = row*N + col), bus zero-extended to BUS_MAX.
   function automatic logic [W_FLOAT-1:0] elem(input logic [BUS_MAX-1:0] bus, input int unsigned k);
      logic [BUS_AW-1:0] base;
      base = BUS_AW'(k * W_FLOAT);
      return bus[base +: W_FLOAT];
   endfunction

endpackage

// File: rtl/mat_result_serializer_if.sv
// Bundle of the adder-side 4-phase result handshake and the downstream
// element stream. The serializer uses the slave view, its environment the master view.
interface mat_result_serializer_if
   import mat_pkg::*;
#(
   parameter int N = 4,
   parameter int W = W_FLOAT
);

   localparam int RW = $clog2(N);

   logic               result_ready;
   logic [W*N*N-1:0]   result;
   logic               result_ack;

   logic               out_ready;
   logic               out_valid;
   logic [W-1:0]       out_data;
   logic [RW-1:0]      out_row;
   logic [RW-1:0]      out_col;
   logic               out_last;

   modport slave (
      input  result_ready, result, out_ready,
      output result_ack, out_valid, out_data, out_row, out_col, out_last
   );

   modport master (
      output result_ready, result, out_ready,
      input  result_ack, out_valid, out_data, out_row, out_col, out_last
   );

endinterface

// File: rtl/mat_result_serializer.sv
// Captures one N x N matrix from the adder, releases the adder via result_ack
// and streams the buffered elements out row-major, one per valid/ready transfer.
module mat_result_serializer
   import mat_pkg::*;
#(
   parameter int N = 4,
   parameter int W = W_FLOAT
) (
   input  logic                   clk,
   input  logic                   reset,
   mat_result_serializer_if.slave bus,
   output logic                   busy
);

   localparam int              IDXW     = $clog2(N*N);
   localparam int              RW       = $clog2(N);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N*N - 1);
   localparam logic [IDXW-1:0] N_IDX    = IDXW'(N);

   state_t                  state_q, state_d;
   logic [IDXW-1:0]         idx_q, idx_d;
   logic                    ackPend_q, ackPend_d;
   logic [N*N-1:0][W-1:0]   buffer_q, buffer_d;
   logic                    isLast;

   assign isLast = (idx_q == LAST_IDX);

   // State, element index, acknowledge flag and matrix buffer registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         ackPend_q <= 1'b0;
         buffer_q  <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         ackPend_q <= ackPend_d;
         buffer_q  <= buffer_d;
      end
   end

   // Next state: capture only in IDLE, walk the index on each accepted element,
   // and wait in DRAIN until the adder has released its request.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ackPend_d = ackPend_q;
      buffer_d  = buffer_q;

      if (ackPend_q && !bus.result_ready) begin
         ackPend_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (bus.result_ready && !ackPend_q) begin
               buffer_d  = bus.result;
               ackPend_d = 1'b1;
               idx_d     = '0;
               state_d   = SEND;
            end
         end
         SEND: begin
            if (bus.out_ready) begin
               if (!isLast) begin
                  idx_d = idx_q + IDXW'(1);
               end else begin
                  idx_d   = '0;
                  state_d = ackPend_q ? DRAIN : IDLE;
               end
            end
         end
         DRAIN: begin
            if (!ackPend_q || !bus.result_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded purely from registered state so no input reaches an output.
   always_comb begin
      busy           = (state_q != IDLE);
      bus.result_ack = ackPend_q;
      bus.out_valid  = 1'b0;
      bus.out_data   = '0;
      bus.out_row    = '0;
      bus.out_col    = '0;
      bus.out_last   = 1'b0;
      if (state_q == SEND) begin
         bus.out_valid = 1'b1;
         bus.out_data  = buffer_q[idx_q];
         bus.out_row   = RW'(idx_q / N_IDX);
         bus.out_col   = RW'(idx_q % N_IDX);
         bus.out_last  = isLast;
      end
   end

endmodule

// File: tb/tb_mat_result_serializer.sv
// Bench for mat_result_serializer: one 2x2 and one 4x4 instance, a behavioural
// frame model (queue of expected elements per instance) and stream monitors.
module tb_mat_result_serializer;
   import mat_pkg::*;

   localparam int W = W_FLOAT;

   typedef struct {
      logic [31:0] data;
      int          row;
      int          col;
      bit          last;
   } elem_t;

   typedef struct {
      bit          rdyIn;
      logic [31:0] data;
      int          row;
      int          col;
      bit          last;
      bit          ack;
   } vec_t;

   logic  clk;
   logic  reset;
   logic  busy2, busy4;
   int    nChecks = 0;
   int    nFails  = 0;
   int    mode2   = 0;
   int    mode4   = 0;
   int    phase   = 0;
   int    cnt2    = 0;
   int    cnt4    = 0;
   int    pushed2 = 0;
   int    pushed4 = 0;
   elem_t q2[$];
   elem_t q4[$];

   mat_result_serializer_if #(.N(2), .W(W)) if2 ();
   mat_result_serializer_if #(.N(4), .W(W)) if4 ();

   mat_result_serializer #(.N(2), .W(W)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave), .busy(busy2));
   mat_result_serializer #(.N(4), .W(W)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave), .busy(busy4));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(string name, logic [63:0] act, logic [63:0] req);
      nChecks++;
      if (act !== req) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic ackOf(int n);
      return (n == 2) ? if2.result_ack : if4.result_ack;
   endfunction

   function automatic logic busyOf(int n);
      return (n == 2) ? busy2 : busy4;
   endfunction

   function automatic logic validOf(int n);
      return (n == 2) ? if2.out_valid : if4.out_valid;
   endfunction

   function automatic int qSize(int n);
      return (n == 2) ? q2.size() : q4.size();
   endfunction

   function automatic logic readyFor(int mode, int ph);
      case (mode)
         0:       return 1'b1;
         1:       return (ph % 4 == 0) || (ph % 4 == 3);
         2:       return ($urandom_range(0, 1) == 1);
         default: return 1'b0;
      endcase
   endfunction

   task automatic applyStimulus(int n, logic r, logic [511:0] d);
      if (n == 2) begin
         if2.result_ready = r;
         if2.result       = d[127:0];
      end else begin
         if4.result_ready = r;
         if4.result       = d;
      end
   endtask

   // Reference model: a captured frame yields N*N elements in row-major order.
   task automatic pushFrame(int n, logic [511:0] d);
      elem_t e;
      for (int k = 0; k < n*n; k++) begin
         e.data = elem(BUS_MAX'(d), k);
         e.row  = k / n;
         e.col  = k % n;
         e.last = (k == n*n - 1);
         if (n == 2) begin
            q2.push_back(e);
            pushed2++;
         end else begin
            q4.push_back(e);
            pushed4++;
         end
      end
   endtask

   // Adder side of the 4-phase handshake, with a configurable slow release.
   task automatic sendFrame(int n, logic [511:0] d, int hold, bit checkLatency);
      int cnt;
      applyStimulus(n, 1'b1, d);
      cnt = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
      end while (!ackOf(n) && cnt < 200);
      checkOutput($sformatf("ack_seen_n%0d", n), ackOf(n), 1'b1);
      if (!ackOf(n)) begin
         applyStimulus(n, 1'b0, d);
         return;
      end
      if (checkLatency) checkOutput($sformatf("ack_latency_n%0d", n), cnt, 1);
      pushFrame(n, d);
      repeat (hold) begin
         @(posedge clk); #1;
         checkOutput($sformatf("ack_hold_n%0d", n), ackOf(n), 1'b1);
         if (qSize(n) == 0) begin
            checkOutput($sformatf("drain_busy_n%0d", n), busyOf(n), 1'b1);
            checkOutput($sformatf("drain_valid_n%0d", n), validOf(n), 1'b0);
         end
      end
      applyStimulus(n, 1'b0, d);
      checkOutput($sformatf("ack_tail_n%0d", n), ackOf(n), 1'b1);
      @(posedge clk); #1;
      checkOutput($sformatf("ack_release_n%0d", n), ackOf(n), 1'b0);
   endtask

   task automatic waitIdle(int n);
      int cnt;
      cnt = 0;
      while ((qSize(n) != 0 || busyOf(n)) && cnt < 3000) begin
         @(posedge clk); #1;
         cnt++;
      end
      checkOutput($sformatf("idle_reached_n%0d", n), (qSize(n) == 0) && !busyOf(n), 1'b1);
   endtask

   // Downstream ready generators.
   initial begin
      if2.out_ready = 1'b1;
      if4.out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         phase++;
         if2.out_ready = readyFor(mode2, phase);
         if4.out_ready = readyFor(mode4, phase);
      end
   end

   // Stream monitor for the 2x2 instance: transfers against the model, stalls held stable.
   initial begin
      elem_t       want;
      bit          stall;
      logic [31:0] pd;
      logic        pr, pc, pl;
      stall = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               checkOutput("stall2_valid", if2.out_valid, 1'b1);
               checkOutput("stall2_data", if2.out_data, pd);
               checkOutput("stall2_row", if2.out_row, pr);
               checkOutput("stall2_col", if2.out_col, pc);
               checkOutput("stall2_last", if2.out_last, pl);
            end
            if (if2.out_valid && if2.out_ready) begin
               cnt2++;
               checkOutput("xfer2_expected", q2.size() > 0, 1'b1);
               if (q2.size() > 0) begin
                  want = q2.pop_front();
                  checkOutput("xfer2_data", if2.out_data, want.data);
                  checkOutput("xfer2_row", if2.out_row, want.row);
                  checkOutput("xfer2_col", if2.out_col, want.col);
                  checkOutput("xfer2_last", if2.out_last, want.last);
               end
            end
            stall = if2.out_valid && !if2.out_ready;
            pd = if2.out_data;
            pr = if2.out_row;
            pc = if2.out_col;
            pl = if2.out_last;
         end
      end
   end

   // Stream monitor for the 4x4 instance.
   initial begin
      elem_t       want;
      bit          stall;
      logic [31:0] pd;
      logic [1:0]  pr, pc;
      logic        pl;
      stall = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               checkOutput("stall4_valid", if4.out_valid, 1'b1);
               checkOutput("stall4_data", if4.out_data, pd);
               checkOutput("stall4_row", if4.out_row, pr);
               checkOutput("stall4_col", if4.out_col, pc);
               checkOutput("stall4_last", if4.out_last, pl);
            end
            if (if4.out_valid && if4.out_ready) begin
               cnt4++;
               checkOutput("xfer4_expected", q4.size() > 0, 1'b1);
               if (q4.size() > 0) begin
                  want = q4.pop_front();
                  checkOutput("xfer4_data", if4.out_data, want.data);
                  checkOutput("xfer4_row", if4.out_row, want.row);
                  checkOutput("xfer4_col", if4.out_col, want.col);
                  checkOutput("xfer4_last", if4.out_last, want.last);
               end
            end
            stall = if4.out_valid && !if4.out_ready;
            pd = if4.out_data;
            pr = if4.out_row;
            pc = if4.out_col;
            pl = if4.out_last;
         end
      end
   end

   // Main sequence: reset, directed corner cases, then randomized frames.
   initial begin
      vec_t         tbl[4];
      logic [511:0] d, d2;
      int           base;

      reset = 1'b0;
      applyStimulus(2, 1'b0, '0);
      applyStimulus(4, 1'b0, '0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ack2", if2.result_ack, 1'b0);
      checkOutput("rst_valid2", if2.out_valid, 1'b0);
      checkOutput("rst_data2", if2.out_data, 32'h0);
      checkOutput("rst_busy2", busy2, 1'b0);
      checkOutput("rst_ack4", if4.result_ack, 1'b0);
      checkOutput("rst_valid4", if4.out_valid, 1'b0);
      checkOutput("rst_data4", if4.out_data, 32'h0);
      checkOutput("rst_row4", if4.out_row, 2'd0);
      checkOutput("rst_col4", if4.out_col, 2'd0);
      checkOutput("rst_last4", if4.out_last, 1'b0);
      checkOutput("rst_busy4", busy4, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;

      // 2x2 frame, ready held high, adder releases as soon as it sees ack.
      $display("[TB] 2x2 table-driven frame");
      tbl[0] = '{1'b0, 32'h41D5EB85, 0, 0, 1'b0, 1'b1};
      tbl[1] = '{1'b0, 32'hC0947AE1, 0, 1, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 32'h40CAE148, 1, 0, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 32'hC1000000, 1, 1, 1'b1, 1'b0};
      d = '0;
      d[127:0] = 128'hC1000000_40CAE148_C0947AE1_41D5EB85;
      applyStimulus(2, 1'b1, d);
      checkOutput("pre_ack2", if2.result_ack, 1'b0);
      checkOutput("pre_valid2", if2.out_valid, 1'b0);
      @(posedge clk); #1;
      pushFrame(2, d);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("tbl%0d_valid", i), if2.out_valid, 1'b1);
         checkOutput($sformatf("tbl%0d_data", i), if2.out_data, tbl[i].data);
         checkOutput($sformatf("tbl%0d_row", i), if2.out_row, tbl[i].row);
         checkOutput($sformatf("tbl%0d_col", i), if2.out_col, tbl[i].col);
         checkOutput($sformatf("tbl%0d_last", i), if2.out_last, tbl[i].last);
         checkOutput($sformatf("tbl%0d_ack", i), if2.result_ack, tbl[i].ack);
         applyStimulus(2, tbl[i].rdyIn, d);
         @(posedge clk); #1;
      end
      checkOutput("tbl_end_valid", if2.out_valid, 1'b0);
      checkOutput("tbl_end_busy", busy2, 1'b0);

      // 4x4 frame with the 1,0,0,1 out_ready pattern.
      $display("[TB] 4x4 frame with stalls");
      mode4 = 1;
      for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom();
      d[31:0]    = 32'h416D47AE;
      d[511:480] = 32'h41C6B852;
      base = cnt4;
      sendFrame(4, d, 0, 1'b1);
      waitIdle(4);
      checkOutput("frame4_count", cnt4 - base, 16);
      mode4 = 0;

      // Slow release: stream ends first, result_ack held until ready drops.
      $display("[TB] slow adder release");
      for (int i = 0; i < 4; i++) d[32*i +: 32] = $urandom();
      base = cnt2;
      sendFrame(2, d, 20, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("slow_valid", if2.out_valid, 1'b0);
      checkOutput("slow_busy", busy2, 1'b0);
      checkOutput("slow_count", cnt2 - base, 4);

      // Back-to-back frames.
      $display("[TB] back-to-back frames");
      for (int i = 0; i < 4; i++) d[32*i +: 32] = $urandom();
      d2 = '0;
      d2[127:0] = {4{32'h3F800000}};
      base = cnt2;
      sendFrame(2, d, 0, 1'b1);
      sendFrame(2, d2, 0, 1'b0);
      waitIdle(2);
      checkOutput("b2b_count", cnt2 - base, 8);

      // Reset mid-stream at idx 2 of a 4x4 frame.
      $display("[TB] reset mid-stream");
      for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom();
      applyStimulus(4, 1'b1, d);
      @(posedge clk); #1;
      checkOutput("mid_ack", if4.result_ack, 1'b1);
      pushFrame(4, d);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("mid_idx2_data", if4.out_data, elem(BUS_MAX'(d), 2));
      checkOutput("mid_idx2_row", if4.out_row, 2'd0);
      checkOutput("mid_idx2_col", if4.out_col, 2'd2);
      reset = 1'b0;
      #1;
      checkOutput("mid_rst_valid", if4.out_valid, 1'b0);
      checkOutput("mid_rst_ack", if4.result_ack, 1'b0);
      checkOutput("mid_rst_busy", busy4, 1'b0);
      q4.delete();
      applyStimulus(4, 1'b0, d);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom();
      base = cnt4;
      sendFrame(4, d, 0, 1'b1);
      waitIdle(4);
      checkOutput("post_rst_count", cnt4 - base, 16);

      // out_ready low for 50 cycles at idx 0 while the handshake completes.
      $display("[TB] long downstream stall");
      mode2 = 3;
      for (int i = 0; i < 4; i++) d[32*i +: 32] = $urandom();
      sendFrame(2, d, 2, 1'b1);
      repeat (50) @(posedge clk);
      #1;
      checkOutput("stall_valid", if2.out_valid, 1'b1);
      checkOutput("stall_data", if2.out_data, elem(BUS_MAX'(d), 0));
      checkOutput("stall_row", if2.out_row, 1'b0);
      checkOutput("stall_col", if2.out_col, 1'b0);
      mode2 = 0;
      waitIdle(2);

      // Randomized frames, ready patterns and release delays on both sizes.
      $display("[TB] randomized frames");
      for (int r = 0; r < 12; r++) begin
         int n;
         bit sync;
         n = (r % 2 == 0) ? 4 : 2;
         if (n == 2) mode2 = $urandom_range(0, 2);
         else        mode4 = $urandom_range(0, 2);
         for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom();
         sync = ($urandom_range(0, 1) == 1);
         if (sync) waitIdle(n);
         sendFrame(n, d, $urandom_range(0, 25), sync);
      end
      mode2 = 0;
      mode4 = 0;
      waitIdle(2);
      waitIdle(4);
      checkOutput("total2", cnt2, pushed2);
      checkOutput("total4", cnt4 - 2, pushed4 - 16);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
